// File: rtl/self_test_pkg.sv
// Shared types and the Intel-HEX record checksum for the self-test monitor.
// Pure declarations; no state, no flow control.
package self_test_pkg;

  localparam int MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RUNNING = 2'b00,
    PASS    = 2'b01,
    FAIL    = 2'b10,
    TIMEOUT = 2'b11
  } status_t;

  // Record layout: byte count, 16-bit index (hi, lo), type 00, then data bytes.
  function automatic logic [7:0] hex_cksum(input logic [15:0]           idx,
                                           input logic [MAX_DATA_W-1:0] data,
                                           input int                    nbytes);
    logic [7:0] sum;
    sum = 8'(nbytes) + idx[15:8] + idx[7:0];
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (i < nbytes) sum = sum + data[8*i +: 8];
    end
    return 8'h00 - sum;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO, one-cycle write-to-read latency, show-ahead read port.
// Push on full is accepted only when a pop happens in the same cycle.
module console_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/self_test_monitor.sv
// Self-test host: bus passthrough with console snoop, termination detect, then RAM dump.
// Console and dump outputs are valid/ready; a full console FIFO stalls the core via core_busy.
module self_test_monitor
  import self_test_pkg::*;
#(
  parameter  int                ADDR_W         = 32,
  parameter  int                DATA_W         = 32,
  parameter  int                NUM_CONSOLE    = 2,
  parameter  logic [ADDR_W-1:0] CONSOLE_BASE   = 32'h0000_0000,
  parameter  logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_0FF0,
  parameter  int                TIMEOUT_CYCLES = 200000,
  parameter  logic [ADDR_W-1:0] DUMP_BASE      = 32'h0000_0000,
  parameter  int                DUMP_WORDS     = 2048,
  parameter  int                FIFO_DEPTH     = 8,
  localparam int                CW             = (NUM_CONSOLE > 1) ? $clog2(NUM_CONSOLE) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic                core_ren,
  input  logic                core_wen,
  input  logic [DATA_W/8-1:0] core_byte_en,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [DATA_W/8-1:0] mem_byte_en,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_busy,
  input  logic                core_halt,
  output logic                con_valid,
  input  logic                con_ready,
  output logic [CW-1:0]       con_chan,
  output logic [7:0]          con_char,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [15:0]         dump_index,
  output logic [DATA_W-1:0]   dump_data,
  output logic [7:0]          dump_cksum,
  output logic                dump_done,
  output logic [1:0]          status,
  output logic [DATA_W-1:0]   fail_code,
  output logic [63:0]         cycle_count
);

  localparam int NB     = DATA_W / 8;
  localparam int IDX_W  = ($clog2(DUMP_WORDS) > 16) ? $clog2(DUMP_WORDS) : 16;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

  state_t            state_q, state_d;
  status_t           status_q, status_d;
  logic [DATA_W-1:0] fail_code_q, fail_code_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic              hit;
  logic [CW-1:0]     hit_chan;
  logic              stall;
  logic              tohost_wr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [CW+7:0]     fifo_rd_dat;

  always_comb begin
    hit      = 1'b0;
    hit_chan = '0;
    for (int i = 0; i < NUM_CONSOLE; i++) begin
      if (core_wen && core_addr == CONSOLE_BASE + ADDR_W'(4 * i)) begin
        hit      = 1'b1;
        hit_chan = CW'(i);
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign fifo_pop  = !fifo_empty && con_ready;
  assign stall     = (state_q == S_RUN) && hit && fifo_full && !fifo_pop;
  assign con_valid = !fifo_empty;
  assign con_chan  = fifo_rd_dat[CW+7:8];
  assign con_char  = fifo_rd_dat[7:0];

  console_fifo #(
    .WIDTH (CW + 8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_data ({hit_chan, core_wdata[DATA_W-1 -: 8]}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    idx_d       = idx_q;
    word_d      = word_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_byte_en = '0;
    core_rdata  = '0;
    core_busy   = 1'b1;
    fifo_push   = 1'b0;
    tohost_wr   = 1'b0;
    dump_valid  = 1'b0;
    dump_done   = 1'b0;

    case (state_q)
      S_RUN: begin
        mem_addr    = core_addr;
        mem_wdata   = core_wdata;
        mem_ren     = core_ren;
        mem_wen     = core_wen && !stall;
        mem_byte_en = core_byte_en;
        core_rdata  = mem_rdata;
        core_busy   = mem_busy || stall;
        fifo_push   = hit && !core_busy;
        tohost_wr   = core_wen && !core_busy && core_addr == TOHOST_ADDR && core_wdata != '0;
        if (tohost_wr) begin
          status_d = (core_wdata == DATA_W'(1)) ? PASS : FAIL;
          if (core_wdata != DATA_W'(1)) fail_code_d = core_wdata >> 1;
          state_d = S_DRAIN;
        end else if (core_halt) begin
          status_d = PASS;
          state_d  = S_DRAIN;
        end else if (cycle_q == 64'(TIMEOUT_CYCLES - 1)) begin
          status_d = TIMEOUT;
          state_d  = S_DRAIN;
        end else begin
          cycle_d = cycle_q + 64'd1;
        end
      end
      S_DRAIN: begin
        if (fifo_count == '0) state_d = S_DUMP_RD;
      end
      S_DUMP_RD: begin
        mem_ren     = 1'b1;
        mem_addr    = DUMP_BASE + ADDR_W'({idx_q, 2'b00});
        mem_byte_en = '1;
        if (!mem_busy) begin
          word_d = mem_rdata;
          if (mem_rdata != '0) begin
            state_d = S_DUMP_OUT;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DUMP_OUT: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        dump_done = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RUN;
      status_q    <= RUNNING;
      fail_code_q <= '0;
      cycle_q     <= '0;
      idx_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
    end
  end

  assign status      = status_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_q;
  assign dump_index  = idx_q[15:0];
  assign dump_data   = word_q;
  assign dump_cksum  = hex_cksum(idx_q[15:0], MAX_DATA_W'(word_q), NB);

endmodule

// File: tb/tb_self_test_monitor.sv
// Directed bench for self_test_monitor: console, termination, dump and reset abort.
module tb_self_test_monitor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_ren;
  logic        core_wen;
  logic [3:0]  core_byte_en;
  logic [31:0] core_rdata;
  logic        core_busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        core_halt;
  logic        con_valid;
  logic        con_ready;
  logic [0:0]  con_chan;
  logic [7:0]  con_char;
  logic        dump_valid;
  logic        dump_ready;
  logic [15:0] dump_index;
  logic [31:0] dump_data;
  logic [7:0]  dump_cksum;
  logic        dump_done;
  logic [1:0]  status;
  logic [31:0] fail_code;
  logic [63:0] cycle_count;

  logic [31:0] ram [16];
  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  // Read-only combinational RAM; core writes are not stored.
  assign mem_rdata = ram[mem_addr[5:2]];

  self_test_monitor #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .NUM_CONSOLE    (2),
    .CONSOLE_BASE   (32'h0000_0000),
    .TOHOST_ADDR    (32'h0000_0FF0),
    .TIMEOUT_CYCLES (100),
    .DUMP_BASE      (32'h0000_0000),
    .DUMP_WORDS     (16),
    .FIFO_DEPTH     (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_ren     (core_ren),
    .core_wen     (core_wen),
    .core_byte_en (core_byte_en),
    .core_rdata   (core_rdata),
    .core_busy    (core_busy),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_byte_en  (mem_byte_en),
    .mem_rdata    (mem_rdata),
    .mem_busy     (mem_busy),
    .core_halt    (core_halt),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .con_chan     (con_chan),
    .con_char     (con_char),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_index   (dump_index),
    .dump_data    (dump_data),
    .dump_cksum   (dump_cksum),
    .dump_done    (dump_done),
    .status       (status),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    core_addr    = '0;
    core_wdata   = '0;
    core_ren     = 1'b0;
    core_wen     = 1'b0;
    core_byte_en = '0;
    core_halt    = 1'b0;
    mem_busy     = 1'b0;
    con_ready    = 1'b0;
    dump_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    core_addr    = a;
    core_wdata   = d;
    core_wen     = 1'b1;
    core_byte_en = 4'hF;
    #1;
    k = 0;
    while (core_busy && k < 50) begin
      cyc();
      k++;
    end
    chk("bus_write_wait", core_busy, 0);
    cyc();
    core_wen   = 1'b0;
    core_wdata = '0;
  endtask

  task automatic wait_dump_valid(input string tag);
    int k;
    k = 0;
    while (!dump_valid && k < 60) begin
      cyc();
      k++;
    end
    chk(tag, dump_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_got;
    int recs;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    RST = 1'b1;
    idle_inputs();

    // Reset values and passthrough
    do_reset();
    chk("rst_status", status, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_con_valid", con_valid, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_done", dump_done, 0);
    ram[2] = 32'h1234_5678;
    core_addr = 32'h8; core_ren = 1'b1;
    #1;
    chk("pass_rdata", core_rdata, 32'h1234_5678);
    chk("pass_mem_ren", mem_ren, 1);
    core_ren = 1'b0; ram[2] = '0;

    // Console order on channel 0 with consumer always ready
    con_ready = 1'b1;
    bus_write(32'h0, 32'h4100_0000);
    chk("con_a_valid", con_valid, 1);
    chk("con_a_char", con_char, 8'h41);
    chk("con_a_chan", con_chan, 0);
    bus_write(32'h0, 32'h4200_0000);
    chk("con_b_valid", con_valid, 1);
    chk("con_b_char", con_char, 8'h42);
    cyc();
    chk("con_empty_after", con_valid, 0);

    // FIFO full backpressure on channel 1
    do_reset();
    for (int k = 0; k < 8; k++) bus_write(32'h4, {8'(8'h61 + k), 24'h0});
    core_addr = 32'h4; core_wdata = 32'h6900_0000; core_wen = 1'b1; core_byte_en = 4'hF;
    #1;
    chk("full_busy", core_busy, 1);
    chk("full_mem_wen", mem_wen, 0);
    chk("full_char_head", con_char, 8'h61);
    chk("full_chan", con_chan, 1);
    cyc();
    cyc();
    chk("full_busy_hold", core_busy, 1);
    chk("full_char_stable", con_char, 8'h61);
    con_ready = 1'b1;
    #1;
    chk("full_pushpop_busy", core_busy, 0);
    chk("full_pushpop_wen", mem_wen, 1);
    chk("full_pushpop_wdata", mem_wdata, 32'h6900_0000);
    cyc();
    core_wen = 1'b0;
    n_got = 1;
    for (int k = 0; k < 20 && n_got < 9; k++) begin
      if (con_valid) begin
        chk("drain_char", con_char, 8'(8'h61 + n_got));
        n_got++;
      end
      cyc();
    end
    chk("drain_total", n_got, 9);
    chk("drain_empty", con_valid, 0);

    // Tohost failure: drain holds off the dump until the console is empty
    do_reset();
    bus_write(32'h4, 32'h5A00_0000);
    bus_write(32'hFF0, 32'd5);
    chk("fail_status", status, 2'b10);
    chk("fail_code", fail_code, 2);
    core_addr = 32'h0; core_ren = 1'b1;
    #1;
    chk("drain_busy", core_busy, 1);
    chk("drain_mem_ren", mem_ren, 0);
    cyc(); cyc(); cyc();
    chk("drain_no_dump", mem_ren, 0);
    chk("drain_con_held", con_valid, 1);
    con_ready = 1'b1;
    cyc(); cyc();
    chk("dumprd_ren", mem_ren, 1);
    chk("dumprd_addr", mem_addr, 0);
    chk("dumprd_be", mem_byte_en, 4'hF);
    core_ren = 1'b0;
    recs = 0;
    for (int k = 0; k < 60 && !dump_done; k++) begin
      if (dump_valid) recs++;
      cyc();
    end
    chk("zero_ram_done", dump_done, 1);
    chk("zero_ram_records", recs, 0);
    chk("fail_status_kept", status, 2'b10);

    // Tohost 0 ignored; tohost 1 with halt passes; tohost 7 with halt fails
    do_reset();
    bus_write(32'hFF0, 32'd0);
    chk("tohost0_ignored", status, 0);
    core_halt = 1'b1;
    bus_write(32'hFF0, 32'd1);
    core_halt = 1'b0;
    chk("pass_status", status, 2'b01);
    chk("pass_fail_code", fail_code, 0);
    do_reset();
    core_halt = 1'b1;
    bus_write(32'hFF0, 32'd7);
    core_halt = 1'b0;
    chk("prio_status", status, 2'b10);
    chk("prio_fail_code", fail_code, 3);

    // Timeout after 100 idle cycles; counter freezes at 99
    do_reset();
    repeat (99) cyc();
    chk("pre_timeout_cycle", cycle_count, 99);
    chk("pre_timeout_status", status, 0);
    cyc();
    chk("timeout_status", status, 2'b11);
    chk("timeout_cycle", cycle_count, 99);
    repeat (30) cyc();
    chk("timeout_cycle_frozen", cycle_count, 99);
    chk("timeout_dump_done", dump_done, 1);

    // Single record at index 3: 4+00+03+00+DE+AD+BE+EF = 0x33F -> cksum 0xC1
    ram[3] = 32'hDEAD_BEEF;
    do_reset();
    core_halt = 1'b1;
    cyc();
    core_halt = 1'b0;
    chk("halt_status", status, 2'b01);
    wait_dump_valid("rec3_wait");
    chk("rec3_index", dump_index, 3);
    chk("rec3_data", dump_data, 32'hDEAD_BEEF);
    chk("rec3_cksum", dump_cksum, 8'hC1);
    cyc(); cyc();
    chk("rec3_hold_valid", dump_valid, 1);
    chk("rec3_hold_index", dump_index, 3);
    dump_ready = 1'b1;
    cyc();
    recs = 0;
    for (int k = 0; k < 60 && !dump_done; k++) begin
      if (dump_valid) recs++;
      cyc();
    end
    chk("rec3_extra_records", recs, 0);
    chk("rec3_done", dump_done, 1);
    chk("done_core_busy", core_busy, 1);

    // Last index record: 4+00+0F+00+00+00+00+01 = 0x14 -> cksum 0xEC
    ram[3] = '0;
    ram[15] = 32'h0000_0001;
    do_reset();
    core_halt = 1'b1;
    cyc();
    core_halt = 1'b0;
    wait_dump_valid("rec15_wait");
    chk("rec15_index", dump_index, 15);
    chk("rec15_cksum", dump_cksum, 8'hEC);
    chk("rec15_not_done", dump_done, 0);
    dump_ready = 1'b1;
    cyc();
    chk("rec15_done", dump_done, 1);
    chk("rec15_valid_drop", dump_valid, 0);

    // Reset asserted mid-dump aborts everything
    ram[15] = '0;
    ram[3] = 32'hDEAD_BEEF;
    do_reset();
    bus_write(32'hFF0, 32'd5);
    wait_dump_valid("abort_wait");
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("abort_status", status, 0);
    chk("abort_fail_code", fail_code, 0);
    chk("abort_cycle", cycle_count, 0);
    chk("abort_dump_valid", dump_valid, 0);
    chk("abort_dump_done", dump_done, 0);
    chk("abort_con_valid", con_valid, 0);
    chk("abort_core_busy", core_busy, 0);
    dump_ready = 1'b1;
    recs = 0;
    for (int k = 0; k < 10; k++) begin
      if (dump_valid) recs++;
      cyc();
    end
    chk("abort_no_records", recs, 0);
    chk("abort_cycle_runs", cycle_count, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
